// File: rtl/cpu_seq_pkg.sv
// Shared types and encodings for the register-file sequencer.
// SEQ_ILLEGAL_TRAP_EN adds the S_TRAP state for illegal opcodes.
package cpu_seq_pkg;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MOVIMM  = 2'b10;
  localparam logic [1:0] OP_MOVREG  = 2'b00;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM8  = 2'b01;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int OP_MSB  = 12;
  localparam int OP_LSB  = 11;
  localparam int RN_MSB  = 10;
  localparam int RN_LSB  = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 5;
  localparam int SH_MSB  = 4;
  localparam int SH_LSB  = 3;
  localparam int RM_MSB  = 2;
  localparam int RM_LSB  = 0;
  localparam int IMM_MSB = 7;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WR_IMM,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WR_REG
`ifdef SEQ_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// Instruction-source / datapath-control bundle of the sequencer.
interface cpu_seq_ctrl_if #(
  parameter int DW = 16,
  parameter int RW = 3
);
  logic          s;
  logic [DW-1:0] in;
  logic          w;
  logic          err;
  logic [RW-1:0] readnum;
  logic [RW-1:0] writenum;
  logic          write;
  logic          loada;
  logic          loadb;
  logic          loadc;
  logic          loads;
  logic          asel;
  logic          bsel;
  logic [1:0]    vsel;
  logic [1:0]    shift;
  logic [1:0]    aluop;
  logic [DW-1:0] sximm8;

  modport master (
    output s, in,
    input  w, err, readnum, writenum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, shift, aluop, sximm8
  );

  modport slave (
    input  s, in,
    output w, err, readnum, writenum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, shift, aluop, sximm8
  );
endinterface

// File: rtl/cpu_instr_dec.sv
// Combinational instruction-field slicer and class decoder.
module cpu_instr_dec
  import cpu_seq_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic [DW-1:0] ir_i,
  output logic [RW-1:0] rn_o,
  output logic [RW-1:0] rd_o,
  output logic [RW-1:0] rm_o,
  output logic [1:0]    sh_o,
  output logic [1:0]    op_o,
  output logic [DW-1:0] sximm8_o,
  output logic          is_movimm_o,
  output logic          is_movreg_o,
  output logic          is_alu_o,
  output logic          is_cmp_o,
  output logic          is_mvn_o,
  output logic          illegal_o
);
  logic [2:0] opc;

  assign opc      = ir_i[OPC_MSB:OPC_LSB];
  assign op_o     = ir_i[OP_MSB:OP_LSB];
  assign rn_o     = ir_i[RN_MSB:RN_LSB];
  assign rd_o     = ir_i[RD_MSB:RD_LSB];
  assign rm_o     = ir_i[RM_MSB:RM_LSB];
  assign sh_o     = ir_i[SH_MSB:SH_LSB];
  assign sximm8_o = {{(DW-8){ir_i[IMM_MSB]}}, ir_i[IMM_MSB:0]};

  // is_alu covers the two-operand ops that need Rn fetched into A
  assign is_movimm_o = (opc == OPC_MOV) && (op_o == OP_MOVIMM);
  assign is_movreg_o = (opc == OPC_MOV) && (op_o == OP_MOVREG);
  assign is_mvn_o    = (opc == OPC_ALU) && (op_o == OP_MVN);
  assign is_cmp_o    = (opc == OPC_ALU) && (op_o == OP_CMP);
  assign is_alu_o    = (opc == OPC_ALU) && (op_o != OP_MVN);
  assign illegal_o   = !(is_movimm_o || is_movreg_o || is_alu_o || is_mvn_o);
endmodule

// File: rtl/cpu_seq_ctrl.sv
// Moore sequencer driving the 8x16 regfile and A/B/C datapath one micro-step per cycle.
// SEQ_ILLEGAL_TRAP_EN: illegal opcodes park in S_TRAP (err=1) until reset.
module cpu_seq_ctrl
  import cpu_seq_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  cpu_seq_ctrl_if.slave bus
);
  state_t        state_q, state_d;
  logic [DW-1:0] ir_q, ir_d;

  logic [RW-1:0] rn, rd, rm;
  logic [1:0]    sh, op;
  logic [DW-1:0] sximm8;
  logic          is_movimm, is_movreg, is_alu, is_cmp, is_mvn, illegal;

  cpu_instr_dec #(.DW(DW), .RW(RW)) u_dec (
    .ir_i        (ir_q),
    .rn_o        (rn),
    .rd_o        (rd),
    .rm_o        (rm),
    .sh_o        (sh),
    .op_o        (op),
    .sximm8_o    (sximm8),
    .is_movimm_o (is_movimm),
    .is_movreg_o (is_movreg),
    .is_alu_o    (is_alu),
    .is_cmp_o    (is_cmp),
    .is_mvn_o    (is_mvn),
    .illegal_o   (illegal)
  );

  assign bus.sximm8 = sximm8;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    bus.w        = 1'b0;
    bus.err      = 1'b0;
    bus.readnum  = '0;
    bus.writenum = '0;
    bus.write    = 1'b0;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.loadc    = 1'b0;
    bus.loads    = 1'b0;
    bus.asel     = 1'b0;
    bus.bsel     = 1'b0;
    bus.vsel     = VSEL_C;
    bus.shift    = 2'b00;
    bus.aluop    = 2'b00;
    unique case (state_q)
      S_WAIT: begin
        bus.w = 1'b1;
        if (bus.s) begin
          ir_d    = bus.in;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_movimm)                state_d = S_WR_IMM;
        else if (is_movreg || is_mvn) state_d = S_GET_B;
        else if (is_alu)              state_d = S_GET_A;
`ifdef SEQ_ILLEGAL_TRAP_EN
        else                          state_d = S_TRAP;
`else
        else                          state_d = S_WAIT;
`endif
      end
      S_WR_IMM: begin
        bus.writenum = rn;
        bus.vsel     = VSEL_IMM8;
        bus.write    = 1'b1;
        state_d      = S_WAIT;
      end
      S_GET_A: begin
        bus.readnum = rn;
        bus.loada   = 1'b1;
        state_d     = S_GET_B;
      end
      S_GET_B: begin
        bus.readnum = rm;
        bus.loadb   = 1'b1;
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        // MOV Rd,Rm is an ADD with A forced to zero
        bus.shift = sh;
        bus.aluop = is_movreg ? OP_ADD : op;
        bus.asel  = is_movreg || is_mvn;
        if (is_cmp) begin
          bus.loads = 1'b1;
          state_d   = S_WAIT;
        end else begin
          bus.loadc = 1'b1;
          state_d   = S_WR_REG;
        end
      end
      S_WR_REG: begin
        bus.writenum = rd;
        bus.vsel     = VSEL_C;
        bus.write    = 1'b1;
        state_d      = S_WAIT;
      end
`ifdef SEQ_ILLEGAL_TRAP_EN
      S_TRAP: bus.err = 1'b1;
`endif
      default: state_d = S_WAIT;
    endcase
  end
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: per-cycle strobe checks plus a write-pulse scoreboard.
module tb_cpu_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic [2:0]  wn;
    logic [1:0]  vs;
    logic [15:0] imm;
  } wr_t;

  wr_t         exp_wr[$];
  logic [20:0] exp_seq[$];

  cpu_seq_ctrl_if #(.DW(16), .RW(3)) bus ();

  cpu_seq_ctrl #(.DW(16), .RW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] vec(input logic w, input logic err,
      input logic [2:0] rdn, input logic [2:0] wrn, input logic wr,
      input logic la, input logic lb, input logic lc, input logic ls,
      input logic as, input logic [1:0] vs, input logic [1:0] sh,
      input logic [1:0] op);
    return {w, err, rdn, wrn, wr, la, lb, lc, ls, as, 1'b0, vs, sh, op};
  endfunction

  function automatic logic [20:0] obs();
    return {bus.w, bus.err, bus.readnum, bus.writenum, bus.write, bus.loada,
            bus.loadb, bus.loadc, bus.loads, bus.asel, bus.bsel, bus.vsel,
            bus.shift, bus.aluop};
  endfunction

  function automatic logic [15:0] sx8(input logic [15:0] ins);
    return {{8{ins[7]}}, ins[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  localparam logic [20:0] WAITV = 21'h100000;
  localparam logic [20:0] BUSY0 = 21'h000000;

  // Expected per-cycle busy outputs and write pulses, taken from the instruction table
  task automatic model(input logic [15:0] ins);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    opc = ins[15:13]; op = ins[12:11]; rn = ins[10:8];
    rd  = ins[7:5];   sh = ins[4:3];   rm = ins[2:0];
    exp_seq.delete();
    exp_seq.push_back(BUSY0);
    if (opc == 3'b110 && op == 2'b10) begin
      exp_seq.push_back(vec(0,0,0,rn,1,0,0,0,0,0,2'b01,0,0));
      exp_wr.push_back('{wn: rn, vs: 2'b01, imm: sx8(ins)});
    end else if ((opc == 3'b110 && op == 2'b00) || (opc == 3'b101 && op == 2'b11)) begin
      exp_seq.push_back(vec(0,0,rm,0,0,0,1,0,0,0,0,0,0));
      exp_seq.push_back(vec(0,0,0,0,0,0,0,1,0,1,0,sh,(opc == 3'b110) ? 2'b00 : op));
      exp_seq.push_back(vec(0,0,0,rd,1,0,0,0,0,0,0,0,0));
      exp_wr.push_back('{wn: rd, vs: 2'b00, imm: sx8(ins)});
    end else if (opc == 3'b101) begin
      exp_seq.push_back(vec(0,0,rn,0,0,1,0,0,0,0,0,0,0));
      exp_seq.push_back(vec(0,0,rm,0,0,0,1,0,0,0,0,0,0));
      if (op == 2'b01)
        exp_seq.push_back(vec(0,0,0,0,0,0,0,0,1,0,0,sh,op));
      else begin
        exp_seq.push_back(vec(0,0,0,0,0,0,0,1,0,0,0,sh,op));
        exp_seq.push_back(vec(0,0,0,rd,1,0,0,0,0,0,0,0,0));
        exp_wr.push_back('{wn: rd, vs: 2'b00, imm: sx8(ins)});
      end
    end
  endtask

  task automatic run_instr(input string name, input logic [15:0] ins, input logic pulse);
    int n;
    model(ins);
    n = exp_seq.size();
    @(negedge clk);
    chk({name, "_wait_pre"}, obs(), WAITV);
    bus.s = 1'b1; bus.in = ins;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.s  = pulse && (k < n - 1);
      bus.in = 16'($urandom);
      chk($sformatf("%s_c%0d", name, k + 1), obs(), exp_seq[k]);
    end
    @(negedge clk);
    bus.s = 1'b0;
    chk({name, "_wait_post"}, obs(), WAITV);
  endtask

  // Scoreboard: every write pulse must match the oldest outstanding expected write
  always @(negedge clk) begin
    if (bus.write === 1'b1) begin
      if (exp_wr.size() == 0) chk("unexpected_write", bus.write, 0);
      else begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("wr_num", bus.writenum, e.wn);
        chk("wr_vsel", bus.vsel, e.vs);
        chk("wr_sximm8", bus.sximm8, e.imm);
      end
    end
  end

  initial begin
    logic w_exp[7];
    rst_n = 1'b0; bus.s = 1'b0; bus.in = 16'h0;
    #2;
    chk("reset_outputs", obs(), WAITV);
    chk("reset_ir", bus.sximm8, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_instr("movimm_r2", 16'hD207, 1'b0);
    run_instr("movimm_r1", 16'hD1FF, 1'b0);
    run_instr("add",       16'hA168, 1'b0);
    run_instr("cmp",       16'hA902, 1'b0);
    run_instr("mvn",       16'hB8E5, 1'b1);
    run_instr("movreg",    16'hC0A4, 1'b1);
    run_instr("and",       16'hB46A, 1'b1);

    // s held high: one WAIT cycle between back-to-back instructions
    w_exp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_wr.push_back('{wn: 3'd2, vs: 2'b01, imm: 16'h0007});
    exp_wr.push_back('{wn: 3'd2, vs: 2'b01, imm: 16'h0007});
    @(negedge clk);
    bus.s = 1'b1; bus.in = 16'hD207;
    chk("b2b_w0", bus.w, w_exp[0]);
    for (int k = 1; k < 7; k++) begin
      @(negedge clk);
      if (k == 5) bus.s = 1'b0;
      chk($sformatf("b2b_w%0d", k), bus.w, w_exp[k]);
    end

`ifdef SEQ_ILLEGAL_TRAP_EN
    @(negedge clk);
    bus.s = 1'b1; bus.in = 16'hE000;
    @(negedge clk);
    chk("illegal_decode", obs(), BUSY0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("trap_hold_%0d", k), obs(), vec(0,1,0,0,0,0,0,0,0,0,0,0,0));
    end
    bus.s = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk("trap_reset", obs(), WAITV);
    @(negedge clk);
    rst_n = 1'b1;
`else
    run_instr("illegal_e000", 16'hE000, 1'b0);
    run_instr("illegal_c800", 16'hC800, 1'b0);
`endif

    // Reset in S_GET_B of ADD: outputs idle at once, no write afterwards
    model(16'hA168);
    exp_wr.delete();
    @(negedge clk);
    bus.s = 1'b1; bus.in = 16'hA168;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.s = 1'b0;
      chk($sformatf("rst_add_c%0d", k + 1), obs(), exp_seq[k]);
    end
    #1 rst_n = 1'b0;
    #1 chk("rst_async_out", obs(), WAITV);
    chk("rst_async_ir", bus.sximm8, 16'h0000);
    repeat (3) begin
      @(negedge clk);
      chk("rst_held", obs(), WAITV);
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst_after", obs(), WAITV);
    end

    run_instr("post_rst_movimm", 16'hD1FF, 1'b0);
    @(negedge clk);
    chk("sb_empty", exp_wr.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
